// File: rtl/sfifo_pkg.sv
// -----------------------------------------------------------------------------
// sfifo_pkg
// Shared definitions for the sfifo_prog single-clock FIFO:
//   - ptr_width / cnt_width : pointer and fill-count widths for a given depth
//   - legality constants and checks for DEPTH / AF_LEVEL / AE_LEVEL
//   - sfifo_err_t   : sticky error flags (overflow / underflow)
//   - sfifo_flags_t : registered status flags and their reset value
// -----------------------------------------------------------------------------
package sfifo_pkg;

    // Smallest depth that makes sense (a 1-entry FIFO has no pointer to wrap).
    localparam int SFIFO_MIN_DEPTH = 2;
    // almost_full threshold must lie in 1..DEPTH
    localparam int SFIFO_AF_MIN    = 1;
    // almost_empty threshold must lie in 0..DEPTH-1
    localparam int SFIFO_AE_MIN    = 0;

    // Address width for DEPTH entries; pointers wrap explicitly at DEPTH-1.
    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // Count width must represent 0..DEPTH inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit depth_ok(input int depth);
        return depth >= SFIFO_MIN_DEPTH;
    endfunction

    function automatic bit af_level_ok(input int depth, input int af_level);
        return (af_level >= SFIFO_AF_MIN) && (af_level <= depth);
    endfunction

    function automatic bit ae_level_ok(input int depth, input int ae_level);
        return (ae_level >= SFIFO_AE_MIN) && (ae_level <= depth - 1);
    endfunction

    // Sticky error flags; both clear only on flush or reset.
    typedef struct packed {
        logic overflow;
        logic underflow;
    } sfifo_err_t;

    // Registered occupancy flags, all derived from the next fill count.
    typedef struct packed {
        logic wfull;
        logic rempty;
        logic almost_full;
        logic almost_empty;
    } sfifo_flags_t;

    // An empty FIFO: not full, empty, not almost full, almost empty.
    localparam sfifo_flags_t SFIFO_FLAGS_RST = '{
        wfull:        1'b0,
        rempty:       1'b1,
        almost_full:  1'b0,
        almost_empty: 1'b1
    };

endpackage

// File: rtl/sfifo_ram.sv
// -----------------------------------------------------------------------------
// sfifo_ram
// Simple dual-port storage array for sfifo_prog.
// Build option: SFIFO_FWFT_EN
//   undefined : rdata is registered, loads mem[raddr] on re (latency 1),
//               holds otherwise, resets to 0.
//   defined   : rdata is a combinational read of mem[raddr] (fall-through);
//               re and rst_n are then unused.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (read register only)
//   we, waddr, wdata  write port
//   re, raddr, rdata  read port
// The array itself is never reset or cleared so it maps onto block/distributed
// RAM.
// -----------------------------------------------------------------------------
module sfifo_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

`ifdef SFIFO_FWFT_EN
    // Head entry is always visible; the controller only reads when non-empty,
    // so raddr never aliases the entry being written on the same edge.
    assign rdata = mem[raddr];

    logic unused_fwft;
    assign unused_fwft = ^{re, rst_n};
`else
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
`endif

endmodule

// File: rtl/sfifo_prog.sv
// -----------------------------------------------------------------------------
// sfifo_prog
// Single-clock FIFO with arbitrary depth (>= 2), live fill count, registered
// almost-full / almost-empty flags, sticky overflow / underflow errors and a
// synchronous flush.
// Build option: SFIFO_FWFT_EN selects first-word-fall-through read data
// (see sfifo_ram); flag, count and error behaviour is the same in both builds.
// Parameters: DEPTH, WIDTH, AF_LEVEL (1..DEPTH), AE_LEVEL (0..DEPTH-1)
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   flush           synchronous clear of pointers, count, flags and errors
//   winc, wdata     write request / data (accepted when !wfull)
//   rinc, rdata     read request / data (accepted when !rempty)
//   wfull, rempty   count == DEPTH / count == 0
//   almost_full     count >= AF_LEVEL
//   almost_empty    count <= AE_LEVEL
//   fill_cnt        number of stored words
//   overflow        sticky, write attempted while full
//   underflow       sticky, read attempted while empty
// -----------------------------------------------------------------------------
module sfifo_prog
    import sfifo_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int WIDTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         winc,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         rinc,
    output logic [WIDTH-1:0]             rdata,
    output logic                         wfull,
    output logic                         rempty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [cnt_width(DEPTH)-1:0]  fill_cnt,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AF   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] CNT_AE   = CW'(AE_LEVEL);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("sfifo_prog: DEPTH %0d below minimum %0d", DEPTH, SFIFO_MIN_DEPTH);
    end
    if (!af_level_ok(DEPTH, AF_LEVEL)) begin : g_bad_af
        $error("sfifo_prog: AF_LEVEL %0d outside 1..%0d", AF_LEVEL, DEPTH);
    end
    if (!ae_level_ok(DEPTH, AE_LEVEL)) begin : g_bad_ae
        $error("sfifo_prog: AE_LEVEL %0d outside 0..%0d", AE_LEVEL, DEPTH - 1);
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PW-1:0] wptr_q,  wptr_d;
    logic [PW-1:0] rptr_q,  rptr_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    sfifo_flags_t  flags_q, flags_d;
    sfifo_err_t    err_q,   err_d;

    logic wr_acc;
    logic rd_acc;

    // Explicit wrap: DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == PTR_LAST) ? '0 : ptr + PW'(1);
    endfunction

    always_comb begin
        // Acceptance looks only at the registered flags; flush masks both
        // requests so they neither move data nor raise errors.
        wr_acc  = winc && !flags_q.wfull  && !flush;
        rd_acc  = rinc && !flags_q.rempty && !flush;

        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        flags_d = flags_q;

        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
            err_d  = '0;
        end else begin
            if (wr_acc) begin
                wptr_d = ptr_inc(wptr_q);
            end
            if (rd_acc) begin
                rptr_d = ptr_inc(rptr_q);
            end

            unique case ({wr_acc, rd_acc})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase

            // A rejected request latches its error until flush/reset. At
            // full a winc+rinc pair thus pops one word and flags overflow;
            // at empty it pushes one word and flags underflow.
            err_d.overflow  = err_q.overflow  | (winc & flags_q.wfull);
            err_d.underflow = err_q.underflow | (rinc & flags_q.rempty);
        end

        // Flags track the next count so they are correct right after the
        // edge that changes it (a zero count reproduces the reset flags).
        flags_d.wfull        = (cnt_d == CNT_FULL);
        flags_d.rempty       = (cnt_d == '0);
        flags_d.almost_full  = (cnt_d >= CNT_AF);
        flags_d.almost_empty = (cnt_d <= CNT_AE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            flags_q <= SFIFO_FLAGS_RST;
            err_q   <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            flags_q <= flags_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    sfifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (PW)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_acc),
        .waddr (wptr_q),
        .wdata (wdata),
        .re    (rd_acc),
        .raddr (rptr_q),
        .rdata (rdata)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wfull        = flags_q.wfull;
    assign rempty       = flags_q.rempty;
    assign almost_full  = flags_q.almost_full;
    assign almost_empty = flags_q.almost_empty;
    assign fill_cnt     = cnt_q;
    assign overflow     = err_q.overflow;
    assign underflow    = err_q.underflow;

endmodule
